// File: rtl/spi_pkt_controller_if.sv
// Signal bundle between the SPI byte engine / sample FIFO / register bank and the packet controller.
// Byte handshake: spi_c_data_in is valid only in a cycle where spi_c_data_stb is high; there is no back-pressure, every strobed byte is consumed.
interface spi_pkt_controller_if #(
    parameter int SPACE_W = 13,
    parameter int NREG    = 2,
    parameter int REG_W   = 8
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [7:0]         spi_c_data_in;
    logic               spi_c_data_stb;
    logic               spi_tsx_start;
    logic [7:0]         spi_c_data_out;
    logic [SPACE_W-1:0] fifo_space_free;
    logic               fifo_full;
    logic [7:0]         fifo_data_in;
    logic               fifo_wr;
    logic [AW-1:0]      reg_addr;
    logic [REG_W-1:0]   reg_data;
    logic               reg_wr;
    logic               busy;
    logic [2:0]         state;

    modport master (
        output spi_c_data_in, spi_c_data_stb, spi_tsx_start, fifo_space_free, fifo_full,
        input  spi_c_data_out, fifo_data_in, fifo_wr, reg_addr, reg_data, reg_wr, busy, state
    );

    modport slave (
        input  spi_c_data_in, spi_c_data_stb, spi_tsx_start, fifo_space_free, fifo_full,
        output spi_c_data_out, fifo_data_in, fifo_wr, reg_addr, reg_data, reg_wr, busy, state
    );
endinterface

// File: rtl/spi_pkt_controller.sv
// Packet decoder on the SPI byte stream: FIFO-space readback, indexed register writes,
// IQ sample streaming into the FIFO and sticky status readback. State is visible on bus.state.
module spi_pkt_controller #(
    parameter int SPACE_W = 13,
    parameter int NREG    = 2,
    parameter int REG_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_pkt_controller_if.slave bus
);
    localparam int SB   = (SPACE_W + 7) / 8;
    localparam int SR_W = 8 * SB;
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int RB   = REG_W / 8;
    localparam int TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TYPE     = 3'd1;
    localparam logic [2:0] S_LEN      = 3'd2;
    localparam logic [2:0] S_SPACE    = 3'd3;
    localparam logic [2:0] S_REG_IDX  = 3'd4;
    localparam logic [2:0] S_REG_DATA = 3'd5;
    localparam logic [2:0] S_FIFO     = 3'd6;
    localparam logic [2:0] S_STATUS   = 3'd7;

    logic [2:0]       state, state_n;
    logic [7:0]       out_n, fdata_n;
    logic             fwr_n, rwr_n, busy_n;
    logic [AW-1:0]    raddr_n, idx_q, idx_n;
    logic [REG_W-1:0] rdata_n, shadow, shadow_n;
    logic [7:0]       type_q, type_n, cnt, cnt_n, drop_cnt, drop_n;
    logic [SR_W-1:0]  sr, sr_n, space_ext;
    logic [TW-1:0]    to_cnt, to_cnt_n;
    logic             ovf, ovf_n, type_err, type_err_n, addr_err, addr_err_n, to_err, to_err_n;

    assign space_ext = SR_W'(bus.fifo_space_free);
    assign bus.state = state;

    // cnt is shared: bytes left in SPACE/REG_DATA, remaining samples in FIFO, phase in STATUS.
    always_comb begin
        state_n    = state;
        out_n      = bus.spi_c_data_out;
        fdata_n    = bus.fifo_data_in;
        fwr_n      = 1'b0;
        raddr_n    = bus.reg_addr;
        rdata_n    = bus.reg_data;
        rwr_n      = 1'b0;
        idx_n      = idx_q;
        type_n     = type_q;
        cnt_n      = cnt;
        sr_n       = sr;
        shadow_n   = shadow;
        to_cnt_n   = '0;
        drop_n     = drop_cnt;
        ovf_n      = ovf;
        type_err_n = type_err;
        addr_err_n = addr_err;
        to_err_n   = to_err;

        if (bus.spi_tsx_start) begin
            state_n = S_TYPE;
            out_n   = 8'hA5;
        end else if (state != S_IDLE && !bus.spi_c_data_stb && to_cnt == TO_LAST) begin
            state_n  = S_IDLE;
            to_err_n = 1'b1;
        end else if (state != S_IDLE) begin
            if (!bus.spi_c_data_stb) to_cnt_n = to_cnt + 1'b1;
            case (state)
                S_TYPE: if (bus.spi_c_data_stb) begin
                    type_n  = bus.spi_c_data_in;
                    state_n = S_LEN;
                end
                S_LEN: if (bus.spi_c_data_stb) begin
                    case (type_q)
                        8'd0: begin
                            state_n = S_SPACE;
                            sr_n    = space_ext;
                            out_n   = space_ext[SR_W-1 -: 8];
                            cnt_n   = 8'(SB - 1);
                        end
                        8'd1: state_n = S_REG_IDX;
                        8'd2: begin
                            state_n = S_FIFO;
                            cnt_n   = bus.spi_c_data_in;
                        end
                        8'd3: begin
                            state_n = S_STATUS;
                            out_n   = {4'b0, to_err, addr_err, type_err, ovf};
                            cnt_n   = 8'd1;
                        end
                        default: begin
                            state_n    = S_IDLE;
                            type_err_n = 1'b1;
                        end
                    endcase
                end
                S_SPACE: if (bus.spi_c_data_stb) begin
                    if (cnt == 8'd0) begin
                        state_n = S_IDLE;
                        out_n   = 8'h00;
                    end else begin
                        sr_n  = sr << 8;
                        out_n = sr_n[SR_W-1 -: 8];
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_REG_IDX: if (bus.spi_c_data_stb) begin
                    if (32'(bus.spi_c_data_in) >= 32'(NREG)) begin
                        state_n    = S_IDLE;
                        addr_err_n = 1'b1;
                    end else begin
                        idx_n    = bus.spi_c_data_in[AW-1:0];
                        cnt_n    = 8'(RB - 1);
                        shadow_n = '0;
                        state_n  = S_REG_DATA;
                    end
                end
                S_REG_DATA: if (bus.spi_c_data_stb) begin
                    shadow_n = (shadow << 8) | REG_W'(bus.spi_c_data_in);
                    if (cnt == 8'd0) begin
                        raddr_n = idx_q;
                        rdata_n = shadow_n;
                        rwr_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_FIFO: begin
                    if (cnt == 8'd0) begin
                        state_n = S_IDLE;
                    end else if (bus.spi_c_data_stb) begin
                        // A full FIFO drops the byte but the packet keeps its framing.
                        if (!bus.fifo_full) begin
                            fdata_n = bus.spi_c_data_in;
                            fwr_n   = 1'b1;
                        end else begin
                            ovf_n = 1'b1;
                            if (drop_cnt != 8'hFF) drop_n = drop_cnt + 1'b1;
                        end
                        cnt_n = cnt - 1'b1;
                        out_n = space_ext[7:0];
                        if (cnt == 8'd1) state_n = S_IDLE;
                    end
                end
                S_STATUS: if (bus.spi_c_data_stb) begin
                    if (cnt != 8'd0) begin
                        out_n = drop_cnt;
                        cnt_n = 8'd0;
                    end else begin
                        ovf_n      = 1'b0;
                        type_err_n = 1'b0;
                        addr_err_n = 1'b0;
                        to_err_n   = 1'b0;
                        drop_n     = 8'd0;
                        state_n    = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            bus.spi_c_data_out <= '0;
            bus.fifo_data_in   <= '0;
            bus.fifo_wr        <= 1'b0;
            bus.reg_addr       <= '0;
            bus.reg_data       <= '0;
            bus.reg_wr         <= 1'b0;
            bus.busy           <= 1'b0;
            idx_q              <= '0;
            type_q             <= '0;
            cnt                <= '0;
            sr                 <= '0;
            shadow             <= '0;
            to_cnt             <= '0;
            drop_cnt           <= '0;
            ovf                <= 1'b0;
            type_err           <= 1'b0;
            addr_err           <= 1'b0;
            to_err             <= 1'b0;
        end else begin
            state              <= state_n;
            bus.spi_c_data_out <= out_n;
            bus.fifo_data_in   <= fdata_n;
            bus.fifo_wr        <= fwr_n;
            bus.reg_addr       <= raddr_n;
            bus.reg_data       <= rdata_n;
            bus.reg_wr         <= rwr_n;
            bus.busy           <= busy_n;
            idx_q              <= idx_n;
            type_q             <= type_n;
            cnt                <= cnt_n;
            sr                 <= sr_n;
            shadow             <= shadow_n;
            to_cnt             <= to_cnt_n;
            drop_cnt           <= drop_n;
            ovf                <= ovf_n;
            type_err           <= type_err_n;
            addr_err           <= addr_err_n;
            to_err             <= to_err_n;
        end
    end
endmodule

// File: tb/tb_spi_pkt_controller.sv
// Directed bench for spi_pkt_controller: SPACE, REG, FIFO, STATUS packets, bad type/index,
// timeout, restart-on-start and asynchronous reset; FIFO and register writes go through queues.
module tb_spi_pkt_controller;
    localparam int SPACE_W = 13;
    localparam int NREG    = 4;
    localparam int REG_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int AW      = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TYPE     = 3'd1;
    localparam logic [2:0] ST_SPACE    = 3'd3;
    localparam logic [2:0] ST_REG_DATA = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]         exp_fifo_q[$];
    logic [AW+REG_W-1:0] exp_reg_q[$];
    logic [7:0]         fifo_exp;
    logic [AW+REG_W-1:0] reg_exp;

    spi_pkt_controller_if #(.SPACE_W(SPACE_W), .NREG(NREG), .REG_W(REG_W)) bus ();

    spi_pkt_controller #(
        .SPACE_W(SPACE_W), .NREG(NREG), .REG_W(REG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write strobes are popped against the expected queues away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_wr) begin
            check("fifo_wr_expected", 32'(exp_fifo_q.size() > 0), 32'd1);
            if (exp_fifo_q.size() > 0) begin
                fifo_exp = exp_fifo_q.pop_front();
                check("fifo_data", 32'(bus.fifo_data_in), 32'(fifo_exp));
            end
        end
        if (rst_n && bus.reg_wr) begin
            check("reg_wr_expected", 32'(exp_reg_q.size() > 0), 32'd1);
            if (exp_reg_q.size() > 0) begin
                reg_exp = exp_reg_q.pop_front();
                check("reg_write", 32'({bus.reg_addr, bus.reg_data}), 32'(reg_exp));
            end
        end
    end

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic full = 1'b0);
        gap();
        bus.spi_c_data_in  = b;
        bus.fifo_full      = full;
        bus.spi_c_data_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.spi_c_data_stb = 1'b0;
        bus.fifo_full      = 1'b0;
    endtask

    task automatic start_pkt();
        gap();
        bus.spi_tsx_start = 1'b1;
        @(posedge clk);
        #1;
        bus.spi_tsx_start = 1'b0;
    endtask

    task automatic drained(input string tag);
        gap();
        check({tag, "_fifo_q_empty"}, 32'(exp_fifo_q.size()), 32'd0);
        check({tag, "_reg_q_empty"}, 32'(exp_reg_q.size()), 32'd0);
    endtask

    task automatic status_read(input string tag, input logic [7:0] flags, input logic [7:0] drops);
        start_pkt();
        check({tag, "_a5"}, 32'(bus.spi_c_data_out), 32'hA5);
        send(8'h03);
        send(8'h00);
        check({tag, "_flags"}, 32'(bus.spi_c_data_out), 32'(flags));
        send(8'h00);
        check({tag, "_drops"}, 32'(bus.spi_c_data_out), 32'(drops));
        send(8'h00);
        check({tag, "_idle"}, 32'(bus.state), 32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_c_data_in   = 8'h00;
        bus.spi_c_data_stb  = 1'b0;
        bus.spi_tsx_start   = 1'b0;
        bus.fifo_space_free = 13'h1ABC;
        bus.fifo_full       = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(bus.spi_c_data_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("rst_fifo_wr", 32'(bus.fifo_wr), 32'h0);
        check("rst_reg_wr", 32'(bus.reg_wr), 32'h0);
        check("rst_reg_data", 32'(bus.reg_data), 32'h0);
        rst_n = 1'b1;

        // Space readback: snapshot taken at dispatch, later FIFO changes ignored.
        start_pkt();
        check("t1_a5", 32'(bus.spi_c_data_out), 32'hA5);
        check("t1_busy", 32'(bus.busy), 32'h1);
        check("t1_type_state", 32'(bus.state), 32'(ST_TYPE));
        send(8'h00);
        send(8'h00);
        check("t1_msb", 32'(bus.spi_c_data_out), 32'h1A);
        check("t1_space_state", 32'(bus.state), 32'(ST_SPACE));
        bus.fifo_space_free = 13'h0555;
        send(8'hFF);
        check("t1_lsb", 32'(bus.spi_c_data_out), 32'hBC);
        send(8'hFF);
        check("t1_end", 32'(bus.spi_c_data_out), 32'h00);
        check("t1_idle_busy", 32'(bus.busy), 32'h0);
        bus.fifo_space_free = 13'h1ABC;

        // Wide indexed register write, then an out-of-range index.
        start_pkt();
        send(8'h01);
        send(8'h00);
        send(8'h02);
        check("t2_reg_data_state", 32'(bus.state), 32'(ST_REG_DATA));
        send(8'h12);
        check("t2_no_early_wr", 32'(bus.reg_wr), 32'h0);
        exp_reg_q.push_back({2'd2, 16'h1234});
        send(8'h34);
        check("t2_reg_wr", 32'(bus.reg_wr), 32'h1);
        check("t2_idle", 32'(bus.state), 32'(ST_IDLE));
        drained("t2");
        start_pkt();
        send(8'h01);
        send(8'h00);
        send(8'h04);
        check("t2_bad_idx_idle", 32'(bus.state), 32'(ST_IDLE));
        check("t2_hold_data", 32'(bus.reg_data), 32'h1234);
        check("t2_hold_addr", 32'(bus.reg_addr), 32'h2);
        drained("t2b");
        status_read("t2_status", 8'h04, 8'h00);

        // Sample stream with two bytes dropped on a full FIFO.
        start_pkt();
        send(8'h02);
        send(8'h05);
        exp_fifo_q.push_back(8'h01);
        send(8'h01);
        check("t3_space_lsb", 32'(bus.spi_c_data_out), 32'hBC);
        exp_fifo_q.push_back(8'h02);
        send(8'h02);
        send(8'h03, 1'b1);
        check("t3_drop_no_wr", 32'(bus.fifo_wr), 32'h0);
        send(8'h04, 1'b1);
        exp_fifo_q.push_back(8'h05);
        send(8'h05);
        check("t3_idle", 32'(bus.state), 32'(ST_IDLE));
        drained("t3");
        status_read("t3_status1", 8'h01, 8'h02);
        status_read("t3_status2", 8'h00, 8'h00);

        // Unknown type, then a register packet left open until the timeout fires.
        start_pkt();
        send(8'h07);
        check("t4_len_busy", 32'(bus.busy), 32'h1);
        send(8'h00);
        check("t4_bad_type_idle", 32'(bus.state), 32'(ST_IDLE));
        status_read("t4_status_type", 8'h02, 8'h00);
        start_pkt();
        send(8'h01);
        send(8'h00);
        send(8'h02);
        repeat (TIMEOUT - 3) @(posedge clk);
        #1;
        check("t4_still_open", 32'(bus.busy), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("t4_timeout_idle", 32'(bus.state), 32'(ST_IDLE));
        check("t4_timeout_busy", 32'(bus.busy), 32'h0);
        drained("t4");
        status_read("t4_status_to", 8'h08, 8'h00);

        // Restart coincident with a sample strobe.
        start_pkt();
        send(8'h02);
        send(8'h03);
        exp_fifo_q.push_back(8'h0A);
        send(8'h0A);
        gap();
        bus.spi_c_data_in  = 8'h0B;
        bus.spi_c_data_stb = 1'b1;
        bus.spi_tsx_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.spi_c_data_stb = 1'b0;
        bus.spi_tsx_start  = 1'b0;
        check("t5_state", 32'(bus.state), 32'(ST_TYPE));
        check("t5_a5", 32'(bus.spi_c_data_out), 32'hA5);
        check("t5_no_wr", 32'(bus.fifo_wr), 32'h0);
        drained("t5");
        send(8'h03);
        send(8'h00);
        check("t5_flags", 32'(bus.spi_c_data_out), 32'h00);
        send(8'h00);
        send(8'h00);
        check("t5_idle", 32'(bus.state), 32'(ST_IDLE));

        // Asynchronous reset in the middle of a register write.
        start_pkt();
        send(8'h01);
        send(8'h00);
        send(8'h01);
        send(8'h56);
        check("t6_mid_state", 32'(bus.state), 32'(ST_REG_DATA));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("t6_rst_busy", 32'(bus.busy), 32'h0);
        check("t6_rst_data_out", 32'(bus.spi_c_data_out), 32'h0);
        check("t6_rst_reg_data", 32'(bus.reg_data), 32'h0);
        check("t6_rst_reg_addr", 32'(bus.reg_addr), 32'h0);
        check("t6_rst_fifo_data", 32'(bus.fifo_data_in), 32'h0);
        #3;
        rst_n = 1'b1;
        send(8'h78);
        check("t6_no_reg_wr", 32'(bus.reg_wr), 32'h0);
        check("t6_idle", 32'(bus.state), 32'(ST_IDLE));
        drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
